// File: rtl/test_mailbox_if.sv
// CPU-side register bus for the test mailbox: address, direction, write data and read data.
interface test_mailbox_if;
  logic [15:0] address;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  modport master (
    output address,
    output rw,
    output data_in,
    input  data_out
  );

  modport slave (
    input  address,
    input  rw,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/test_mailbox.sv
// Self-test result mailbox: CPU writes RESULT/EXPECT, then commands a compare; done/pass report the verdict.
// Optional idle watchdog is compiled in only when TEST_MAILBOX_WATCHDOG_EN is defined.
module test_mailbox #(
  parameter logic [15:0] BASE_ADDR      = 16'h0200,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60
) (
  input  logic         ph2,
  input  logic         reset,
  test_mailbox_if.slave bus,
  output logic         done,
  output logic         pass
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [1:0] OFF_RESULT = 2'd0;
  localparam logic [1:0] OFF_EXPECT = 2'd1;
  localparam logic [1:0] OFF_CMD    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [7:0] CMD_CHECK = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'h5A;

  state_t      state_q, state_d;
  logic [7:0]  result_q, result_d;
  logic [7:0]  expected_q, expected_d;
  logic [3:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [15:0] offset;
  logic        in_window;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        cmd_check;
  logic        cmd_clear;
  logic        wd_expire;
  logic [7:0]  status;

  // Subtraction wraps, so a window near the top of the address map still decodes correctly.
  assign offset    = bus.address - BASE_ADDR;
  assign in_window = (offset < 16'd4);
  assign reg_sel   = offset[1:0];
  assign wr_en     = in_window && !bus.rw;
  assign cmd_check = wr_en && (reg_sel == OFF_CMD) && (bus.data_in == CMD_CHECK);
  assign cmd_clear = wr_en && (reg_sel == OFF_CMD) && (bus.data_in == CMD_CLEAR);

`ifdef TEST_MAILBOX_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;

  // Counts only while idle; frozen elsewhere so the expiry point is well defined.
  always_comb begin
    wd_d      = wd_q;
    wd_expire = 1'b0;
    if (cmd_clear) begin
      wd_d = '0;
    end else if ((state_q == ST_IDLE) && (wd_q != TIMEOUT_CYCLES)) begin
      wd_d      = wd_q + 16'd1;
      wd_expire = (wd_d == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    expected_d = expected_q;
    count_d    = count_q;
    done_d     = 1'b0;
    pass_d     = 1'b0;

    if (wr_en && (reg_sel == OFF_RESULT)) begin
      result_d = bus.data_in;
    end
    if (wr_en && (reg_sel == OFF_EXPECT)) begin
      expected_d = bus.data_in;
    end

    // CHECK compares the pre-edge register values, so a same-cycle RESULT write lands afterwards.
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_check) begin
          state_d = ST_CHECK;
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_CHECK: begin
        state_d = (result_q == expected_q) ? ST_PASS : ST_FAIL;
        if (count_q != 4'hF) begin
          count_d = count_q + 4'd1;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (cmd_check) begin
          state_d = ST_CHECK;
        end
      end
      ST_TIMEOUT: begin
        state_d = ST_TIMEOUT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd_clear) begin
      state_d    = ST_IDLE;
      result_d   = '0;
      expected_d = '0;
      count_d    = '0;
    end

    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d = (state_d == ST_PASS);
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      expected_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      expected_q <= expected_d;
      count_q    <= count_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign status = {count_q, 1'b0, (state_q == ST_TIMEOUT), pass_q, done_q};

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.rw && in_window) begin
      unique case (reg_sel)
        OFF_RESULT: bus.data_out = result_q;
        OFF_EXPECT: bus.data_out = expected_q;
        OFF_CMD:    bus.data_out = 8'h00;
        OFF_STATUS: bus.data_out = status;
        default:    bus.data_out = 8'h00;
      endcase
    end
  end

  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_test_mailbox.sv
// Directed self-checking bench for test_mailbox: pass/fail verdicts, watchdog, reset, saturation and write ordering.
module tb_test_mailbox;

  localparam logic [15:0] BASE = 16'h0200;

  logic ph2;
  logic reset;
  logic done;
  logic pass;
  int   n_checks;
  int   n_fail;

  test_mailbox_if bus_if ();

  test_mailbox #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16'd60)
  ) dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus_if.slave),
    .done  (done),
    .pass  (pass)
  );

  initial begin
    ph2 = 1'b0;
    forever #10 ph2 = ~ph2;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL sim_timeout: simulation did not finish within the time limit");
    $fatal(1, "[TB] time limit exceeded");
  end

  task automatic bus_write_raw(input logic [15:0] addr, input logic [7:0] val);
    @(negedge ph2);
    bus_if.address = addr;
    bus_if.rw      = 1'b0;
    bus_if.data_in = val;
    @(posedge ph2);
    #1;
    bus_if.rw      = 1'b1;
    bus_if.address = 16'h0000;
    bus_if.data_in = 8'h00;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] val);
    bus_write_raw(BASE + 16'(off), val);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] val);
    bus_if.address = addr;
    bus_if.rw      = 1'b1;
    #1;
    val = bus_if.data_out;
    bus_if.address = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge ph2);
    reset = 1'b1;
    @(posedge ph2);
    @(negedge ph2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    do_reset();
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_status: got %h expected 00", rd); end
    bus_read(BASE + 16'd0, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00", rd); end
  endtask

  task automatic test_pass();
    logic [7:0] rd;
    do_reset();
    bus_write(2'd0, 8'h0C);
    bus_write(2'd1, 8'h0C);
    bus_read(BASE + 16'd1, rd);
    n_checks++; if (rd !== 8'h0C) begin n_fail++; $display("[TB] FAIL expect_readback: got %h expected 0c", rd); end
    bus_write(2'd2, 8'hA5);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_done_early: got %b expected 0", done); end
    @(posedge ph2); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_done: got %b expected 1", done); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_pass: got %b expected 1", pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h13) begin n_fail++; $display("[TB] FAIL pass_status: got %h expected 13", rd); end
    bus_read(BASE + 16'd2, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL cmd_reads_zero: got %h expected 00", rd); end
  endtask

  task automatic test_fail();
    logic [7:0] rd;
    do_reset();
    bus_write(2'd0, 8'h0B);
    bus_write(2'd1, 8'h0C);
    bus_write(2'd2, 8'hA5);
    @(posedge ph2); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL fail_done: got %b expected 1", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL fail_pass: got %b expected 0", pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h11) begin n_fail++; $display("[TB] FAIL fail_status: got %h expected 11", rd); end
    bus_write(2'd0, 8'h0C);
    bus_write(2'd2, 8'hA5);
    @(posedge ph2); #1;
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h23) begin n_fail++; $display("[TB] FAIL recheck_status: got %h expected 23", rd); end
  endtask

  task automatic test_watchdog();
    logic [7:0] rd;
`ifdef TEST_MAILBOX_WATCHDOG_EN
    do_reset();
    repeat (59) @(posedge ph2);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_done_edge59: got %b expected 0", done); end
    @(posedge ph2); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_done_edge60: got %b expected 1", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_pass: got %b expected 0", pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h05) begin n_fail++; $display("[TB] FAIL wd_status: got %h expected 05", rd); end
    bus_write(2'd2, 8'hA5);
    @(posedge ph2); #1;
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h05) begin n_fail++; $display("[TB] FAIL wd_recheck_ignored: got %h expected 05", rd); end
    bus_write(2'd2, 8'h5A);
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL wd_clear_status: got %h expected 00", rd); end
    do_reset();
    repeat (59) @(posedge ph2);
    #1;
    bus_write(2'd2, 8'hA5);
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL wd_race_check_state: got %h expected 00", rd); end
    @(posedge ph2); #1;
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h13) begin n_fail++; $display("[TB] FAIL wd_race_result: got %h expected 13", rd); end
`else
    logic saw_done;
    do_reset();
    saw_done = 1'b0;
    for (int i = 0; i < 210; i++) begin
      @(posedge ph2); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("[TB] FAIL nowd_done: got %b expected 0", saw_done); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL nowd_status: got %h expected 00", rd); end
`endif
  endtask

  task automatic test_reset_during_check();
    logic [7:0] rd;
    do_reset();
    bus_write(2'd0, 8'h0C);
    bus_write(2'd1, 8'h0C);
    bus_write(2'd2, 8'hA5);
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_chk_done: got %b expected 0", done); end
    bus_read(BASE + 16'd0, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_chk_result: got %h expected 00", rd); end
    @(posedge ph2);
    @(negedge ph2);
    reset = 1'b0;
    repeat (2) @(posedge ph2);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_chk_done_after: got %b expected 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_chk_pass_after: got %b expected 0", pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_chk_status: got %h expected 00", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic       all_pass;
    do_reset();
    bus_write(2'd0, 8'h0C);
    bus_write(2'd1, 8'h0C);
    all_pass = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_write(2'd2, 8'hA5);
      @(posedge ph2); #1;
      if (pass !== 1'b1) all_pass = 1'b0;
    end
    n_checks++; if (all_pass !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_all_pass: got %b expected 1", all_pass); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'hF3) begin n_fail++; $display("[TB] FAIL b2b_status_sat: got %h expected f3", rd); end
    bus_write(2'd2, 8'h5A);
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL b2b_clear_status: got %h expected 00", rd); end
    bus_read(BASE + 16'd0, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL b2b_clear_result: got %h expected 00", rd); end
    bus_read(BASE + 16'd1, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL b2b_clear_expect: got %h expected 00", rd); end
  endtask

  task automatic test_write_during_check();
    logic [7:0] rd;
    do_reset();
    bus_write(2'd0, 8'h0C);
    bus_write(2'd1, 8'h0C);
    bus_write(2'd2, 8'hA5);
    bus_write(2'd0, 8'h0D);
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("[TB] FAIL wdc_pass: got %b expected 1", pass); end
    bus_read(BASE + 16'd0, rd);
    n_checks++; if (rd !== 8'h0D) begin n_fail++; $display("[TB] FAIL wdc_result: got %h expected 0d", rd); end
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h13) begin n_fail++; $display("[TB] FAIL wdc_status: got %h expected 13", rd); end
  endtask

  task automatic test_cmd_misc();
    logic [7:0] rd;
    do_reset();
    bus_write(2'd0, 8'h21);
    bus_write_raw(BASE + 16'd4, 8'h77);
    bus_write_raw(BASE - 16'd1, 8'h66);
    bus_read(BASE + 16'd0, rd);
    n_checks++; if (rd !== 8'h21) begin n_fail++; $display("[TB] FAIL window_result: got %h expected 21", rd); end
    bus_read(BASE + 16'd1, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL window_expect: got %h expected 00", rd); end
    bus_if.rw = 1'b0;
    bus_if.data_in = 8'h5A;
    bus_read(BASE + 16'd4, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL outside_read: got %h expected 00", rd); end
    bus_write(2'd2, 8'h33);
    @(posedge ph2); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_cmd_ignored: got %b expected 0", done); end
    bus_write(2'd2, 8'hA5);
    bus_write(2'd2, 8'h5A);
    @(posedge ph2); #1;
    bus_read(BASE + 16'd3, rd);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("[TB] FAIL clear_in_check: got %h expected 00", rd); end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus_if.address = 16'h0000;
    bus_if.rw      = 1'b1;
    bus_if.data_in = 8'h00;
    test_reset();
    test_pass();
    test_fail();
    test_watchdog();
    test_reset_during_check();
    test_back_to_back();
    test_write_during_check();
    test_cmd_misc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
